// File: rtl/ipsxe_floating_point_accum_mc_v1_0_if.sv
// Stream bundle for the multi-channel float accumulator: operand beat in, running-sum beat out.
interface ipsxe_floating_point_accum_mc_v1_0_if #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int CH_WIDTH  = 2
);
    logic [EXP_WIDTH+MAN_WIDTH:0] i_axis_a_tdata;
    logic                         i_axis_operation_tdata;
    logic [CH_WIDTH-1:0]          i_axis_a_tuser;
    logic                         i_axis_a_tvalid;
    logic                         i_axis_a_tlast;
    logic [EXP_WIDTH+MAN_WIDTH:0] o_axis_result_tdata;
    logic [CH_WIDTH-1:0]          o_axis_result_tuser;
    logic                         o_axis_result_tvalid;
    logic                         o_axis_result_tlast;
    logic                         o_invalid_op;
    logic                         o_accum_input_overflow;
    logic                         o_accum_overflow;

    modport slave (
        input  i_axis_a_tdata, i_axis_operation_tdata, i_axis_a_tuser, i_axis_a_tvalid, i_axis_a_tlast,
        output o_axis_result_tdata, o_axis_result_tuser, o_axis_result_tvalid, o_axis_result_tlast,
        output o_invalid_op, o_accum_input_overflow, o_accum_overflow
    );

    modport master (
        output i_axis_a_tdata, i_axis_operation_tdata, i_axis_a_tuser, i_axis_a_tvalid, i_axis_a_tlast,
        input  o_axis_result_tdata, o_axis_result_tuser, o_axis_result_tvalid, o_axis_result_tlast,
        input  o_invalid_op, o_accum_input_overflow, o_accum_overflow
    );
endinterface

// File: rtl/ipsxe_floating_point_accum_mc_v1_0.sv
// Multi-channel float accumulator: classify, float->fixed, per-channel RMW, fixed->float (4 stages).
// IPSXE_FLT_ACCUM_SATURATE_EN: clamp on accumulator overflow instead of going to NaN.
//   state   | meaning
//   ST_NORM | finite running sum held in sum_q
//   ST_NAN  | NaN seen (or overflow); absorbing until tlast
//   ST_PINF | +inf seen
//   ST_NINF | -inf seen
module ipsxe_floating_point_accum_mc_v1_0 #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int MSB       = 32,
    parameter int LSB       = -31,
    parameter int INPUT_MSB = 32,
    parameter int NUM_CH    = 4,
    parameter int CH_WIDTH  = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_aclken,
    ipsxe_floating_point_accum_mc_v1_0_if.slave bus
);
    localparam int W      = 1 + EXP_WIDTH + MAN_WIDTH;
    localparam int ACC_W  = MSB - LSB + 2;
    localparam int BIAS   = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int NORM_W = ACC_W + MAN_WIDTH;

    typedef enum logic [1:0] {ST_NORM, ST_NAN, ST_PINF, ST_NINF} ch_state_e;
    typedef enum logic [2:0] {CL_FIN, CL_ZERO, CL_NAN, CL_PINF, CL_NINF, CL_INOV} op_class_e;

    logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_sign_q, s1_sign_d;
    logic [CH_WIDTH-1:0]     s1_ch_q, s1_ch_d;
    op_class_e               s1_cls_q, s1_cls_d;
    logic [EXP_WIDTH-1:0]    s1_exp_q, s1_exp_d;
    logic [MAN_WIDTH-1:0]    s1_man_q, s1_man_d;

    logic                    s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [CH_WIDTH-1:0]     s2_ch_q, s2_ch_d;
    op_class_e               s2_cls_q, s2_cls_d;
    logic signed [ACC_W-1:0] s2_val_q, s2_val_d;

    logic signed [ACC_W-1:0] sum_q [NUM_CH];
    logic signed [ACC_W-1:0] sum_d [NUM_CH];
    ch_state_e               st_q  [NUM_CH];
    ch_state_e               st_d  [NUM_CH];

    logic                    s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    logic                    s3_inv_q, s3_inv_d, s3_inov_q, s3_inov_d, s3_ovf_q, s3_ovf_d;
    logic [CH_WIDTH-1:0]     s3_ch_q, s3_ch_d;
    ch_state_e               s3_st_q, s3_st_d;
    logic signed [ACC_W-1:0] s3_sum_q, s3_sum_d;

    logic [W-1:0]            out_data_q, out_data_d;
    logic [CH_WIDTH-1:0]     out_ch_q, out_ch_d;
    logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                    out_inv_q, out_inv_d, out_inov_q, out_inov_d, out_ovf_q, out_ovf_d;

    // Stage 1: flush denormals, fold subtract into the sign, classify.
    always_comb begin
        s1_exp_d   = bus.i_axis_a_tdata[W-2 -: EXP_WIDTH];
        s1_man_d   = bus.i_axis_a_tdata[MAN_WIDTH-1:0];
        s1_sign_d  = bus.i_axis_a_tdata[W-1] ^ bus.i_axis_operation_tdata;
        s1_valid_d = bus.i_axis_a_tvalid && (int'(bus.i_axis_a_tuser) < NUM_CH);
        s1_last_d  = bus.i_axis_a_tlast;
        s1_ch_d    = bus.i_axis_a_tuser;
        if (s1_exp_d == '1)
            s1_cls_d = (s1_man_d != '0) ? CL_NAN : (s1_sign_d ? CL_NINF : CL_PINF);
        else if (s1_exp_d == '0)
            s1_cls_d = CL_ZERO;
        else if (int'(s1_exp_d) - BIAS > INPUT_MSB)
            s1_cls_d = CL_INOV;
        else
            s1_cls_d = CL_FIN;
    end

    // Stage 2: finite operand to two's-complement fixed point, truncating below 2^LSB.
    always_comb begin
        int                 sh;
        logic [MAN_WIDTH:0] m_full;
        logic [ACC_W-1:0]   mag;
        m_full = {1'b1, s1_man_q};
        sh     = int'(s1_exp_q) - BIAS - MAN_WIDTH - LSB;
        mag    = '0;
        if (s1_cls_q == CL_FIN) begin
            if (sh >= 0) mag = ACC_W'(m_full) << sh;
            else         mag = ACC_W'(m_full >> (-sh));
        end
        s2_val_d   = s1_sign_q ? -mag : mag;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_last_q;
        s2_ch_d    = s1_ch_q;
        s2_cls_d   = s1_cls_q;
    end

    // Stage 3: read-modify-write of the channel entry in a single cycle, so no forwarding is needed.
    always_comb begin
        logic signed [ACC_W-1:0] base;
        logic signed [ACC_W-1:0] total;
        ch_state_e               cur;
        ch_state_e               nxt;
        logic                    ovf;
        logic                    inv;
        sum_d = sum_q;
        st_d  = st_q;
        base  = '0;
        cur   = ST_NORM;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(s2_ch_q) == c) begin
                base = sum_q[c];
                cur  = st_q[c];
            end
        end
        total = base + s2_val_q;
        ovf   = (base[ACC_W-1] == s2_val_q[ACC_W-1]) && (total[ACC_W-1] != base[ACC_W-1]);
        nxt   = cur;
        inv   = 1'b0;
        case (cur)
            ST_NORM: begin
                case (s2_cls_q)
                    CL_PINF:         nxt = ST_PINF;
                    CL_NINF:         nxt = ST_NINF;
                    CL_NAN, CL_INOV: nxt = ST_NAN;
                    default:         ;
                endcase
`ifdef IPSXE_FLT_ACCUM_SATURATE_EN
                if (ovf) total = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
                if (ovf) nxt = ST_NAN;
`endif
            end
            ST_PINF: if (s2_cls_q == CL_NINF) begin nxt = ST_NAN; inv = 1'b1; end
            ST_NINF: if (s2_cls_q == CL_PINF) begin nxt = ST_NAN; inv = 1'b1; end
            default: ;
        endcase
        // A tlast beat reports its own sum, then leaves the channel clean for the next reduction.
        for (int c = 0; c < NUM_CH; c++) begin
            if (s2_valid_q && int'(s2_ch_q) == c) begin
                sum_d[c] = s2_last_q ? '0 : total;
                st_d[c]  = s2_last_q ? ST_NORM : nxt;
            end
        end
        s3_sum_d   = total;
        s3_st_d    = nxt;
        s3_valid_d = s2_valid_q;
        s3_last_d  = s2_last_q;
        s3_ch_d    = s2_ch_q;
        s3_inv_d   = s2_valid_q && inv;
        s3_inov_d  = s2_valid_q && (s2_cls_q == CL_INOV);
        s3_ovf_d   = s2_valid_q && ovf;
    end

    // Stage 4: sign-magnitude, leading-one normalise, truncate mantissa; special states override.
    always_comb begin
        logic [ACC_W-1:0]     mag;
        logic [NORM_W-1:0]    norm;
        logic [EXP_WIDTH-1:0] e;
        int                   p;
        mag = s3_sum_q[ACC_W-1] ? -s3_sum_q : s3_sum_q;
        p   = 0;
        for (int i = 0; i < ACC_W; i++) if (mag[i]) p = i;
        norm = {mag, {MAN_WIDTH{1'b0}}} << (ACC_W - 1 - p);
        e    = EXP_WIDTH'(p + LSB + BIAS);
        if (mag == '0) out_data_d = '0;
        else           out_data_d = {s3_sum_q[ACC_W-1], e, MAN_WIDTH'(norm >> (ACC_W - 1))};
        case (s3_st_q)
            ST_NAN:  out_data_d = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
            ST_PINF: out_data_d = {1'b0, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            ST_NINF: out_data_d = {1'b1, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
            default: ;
        endcase
        out_valid_d = s3_valid_q;
        out_last_d  = s3_last_q;
        out_ch_d    = s3_ch_q;
        out_inv_d   = s3_inv_q;
        out_inov_d  = s3_inov_q;
        out_ovf_d   = s3_ovf_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0; s1_last_q <= 1'b0; s1_sign_q <= 1'b0; s1_ch_q <= '0;
            s1_cls_q   <= CL_ZERO; s1_exp_q <= '0; s1_man_q <= '0;
            s2_valid_q <= 1'b0; s2_last_q <= 1'b0; s2_ch_q <= '0; s2_cls_q <= CL_ZERO; s2_val_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sum_q[c] <= '0;
                st_q[c]  <= ST_NORM;
            end
            s3_valid_q <= 1'b0; s3_last_q <= 1'b0; s3_ch_q <= '0; s3_st_q <= ST_NORM; s3_sum_q <= '0;
            s3_inv_q   <= 1'b0; s3_inov_q <= 1'b0; s3_ovf_q <= 1'b0;
            out_data_q <= '0; out_ch_q <= '0; out_valid_q <= 1'b0; out_last_q <= 1'b0;
            out_inv_q  <= 1'b0; out_inov_q <= 1'b0; out_ovf_q <= 1'b0;
        end else if (i_aclken) begin
            s1_valid_q <= s1_valid_d; s1_last_q <= s1_last_d; s1_sign_q <= s1_sign_d; s1_ch_q <= s1_ch_d;
            s1_cls_q   <= s1_cls_d; s1_exp_q <= s1_exp_d; s1_man_q <= s1_man_d;
            s2_valid_q <= s2_valid_d; s2_last_q <= s2_last_d; s2_ch_q <= s2_ch_d;
            s2_cls_q   <= s2_cls_d; s2_val_q <= s2_val_d;
            sum_q      <= sum_d;
            st_q       <= st_d;
            s3_valid_q <= s3_valid_d; s3_last_q <= s3_last_d; s3_ch_q <= s3_ch_d;
            s3_st_q    <= s3_st_d; s3_sum_q <= s3_sum_d;
            s3_inv_q   <= s3_inv_d; s3_inov_q <= s3_inov_d; s3_ovf_q <= s3_ovf_d;
            out_data_q <= out_data_d; out_ch_q <= out_ch_d; out_valid_q <= out_valid_d;
            out_last_q <= out_last_d; out_inv_q <= out_inv_d; out_inov_q <= out_inov_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign bus.o_axis_result_tdata    = out_data_q;
    assign bus.o_axis_result_tuser    = out_ch_q;
    assign bus.o_axis_result_tvalid   = out_valid_q;
    assign bus.o_axis_result_tlast    = out_last_q;
    assign bus.o_invalid_op           = out_inv_q;
    assign bus.o_accum_input_overflow = out_inov_q;
    assign bus.o_accum_overflow       = out_ovf_q;
endmodule

// File: tb/tb_ipsxe_floating_point_accum_mc_v1_0.sv
// Directed bench for the multi-channel float accumulator; 3-bit channel index so out-of-range channels are reachable.
module tb_ipsxe_floating_point_accum_mc_v1_0;
    localparam logic [31:0] F_ONE  = 32'h3F800000;
    localparam logic [31:0] F_ZERO = 32'h00000000;
    localparam logic [31:0] F_NAN  = 32'h7FC00000;
`ifdef IPSXE_FLT_ACCUM_SATURATE_EN
    localparam logic [31:0] F_OVF  = 32'h4FFFFFFF;
`else
    localparam logic [31:0] F_OVF  = 32'h7FC00000;
`endif

    logic i_clk;
    logic i_rst;
    logic i_aclken;
    int   n_tests = 0;
    int   n_fail  = 0;

    ipsxe_floating_point_accum_mc_v1_0_if #(.EXP_WIDTH(8), .MAN_WIDTH(23), .CH_WIDTH(3)) bus ();

    ipsxe_floating_point_accum_mc_v1_0 #(.CH_WIDTH(3)) u_dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_aclken (i_aclken),
        .bus      (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d, input logic [2:0] c,
                               input logic l, input logic [2:0] fl);
        cmp({tag, "_valid"}, 32'(bus.o_axis_result_tvalid), 32'd1);
        cmp({tag, "_data"},  bus.o_axis_result_tdata, d);
        cmp({tag, "_ch"},    32'(bus.o_axis_result_tuser), 32'(c));
        cmp({tag, "_last"},  32'(bus.o_axis_result_tlast), 32'(l));
        cmp({tag, "_flags"}, 32'({bus.o_invalid_op, bus.o_accum_input_overflow, bus.o_accum_overflow}), 32'(fl));
    endtask

    task automatic expect_none(input string tag);
        cmp({tag, "_valid"}, 32'(bus.o_axis_result_tvalid), 32'd0);
        cmp({tag, "_flags"}, 32'({bus.o_invalid_op, bus.o_accum_input_overflow, bus.o_accum_overflow}), 32'd0);
    endtask

    task automatic drive(input logic [2:0] ch, input logic [31:0] d, input logic op, input logic last);
        bus.i_axis_a_tvalid        = 1'b1;
        bus.i_axis_a_tuser         = ch;
        bus.i_axis_a_tdata         = d;
        bus.i_axis_operation_tdata = op;
        bus.i_axis_a_tlast         = last;
        @(negedge i_clk);
    endtask

    task automatic nop();
        bus.i_axis_a_tvalid = 1'b0;
        bus.i_axis_a_tlast  = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1;
        i_aclken = 1'b1;
        bus.i_axis_a_tdata = '0;
        bus.i_axis_operation_tdata = 1'b0;
        bus.i_axis_a_tuser = '0;
        bus.i_axis_a_tvalid = 1'b0;
        bus.i_axis_a_tlast = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        expect_none("reset");
        cmp("reset_data", bus.o_axis_result_tdata, 32'h0);

        // interleaved ch0/ch1, result exactly 4 cycles after each beat
        drive(3'd0, F_ONE, 1'b0, 1'b0);
        drive(3'd1, 32'h40600000, 1'b1, 1'b0);
        drive(3'd0, 32'h40200000, 1'b0, 1'b0);
        expect_none("il_early");
        nop(); expect_beat("il_a", F_ONE, 3'd0, 1'b0, 3'b000);
        nop(); expect_beat("il_b", 32'hC0600000, 3'd1, 1'b0, 3'b000);
        nop(); expect_beat("il_c", 32'h40600000, 3'd0, 1'b0, 3'b000);
        nop(); expect_none("il_end");

        // inf handling, NaN until tlast, then the next beat on the same channel restarts from 0
        drive(3'd2, 32'h7F800000, 1'b0, 1'b0);
        drive(3'd2, 32'hFF800000, 1'b0, 1'b0);
        drive(3'd2, F_ONE, 1'b0, 1'b1);
        drive(3'd2, F_ONE, 1'b0, 1'b0);
        expect_beat("inf_p", 32'h7F800000, 3'd2, 1'b0, 3'b000);
        nop(); expect_beat("inf_inv", F_NAN, 3'd2, 1'b0, 3'b100);
        nop(); expect_beat("inf_last", F_NAN, 3'd2, 1'b1, 3'b000);
        nop(); expect_beat("inf_restart", F_ONE, 3'd2, 1'b0, 3'b000);

        // input overflow on ch3 leaves ch0/ch1 sums intact
        drive(3'd3, 32'h50000000, 1'b0, 1'b0);
        drive(3'd0, F_ZERO, 1'b0, 1'b0);
        drive(3'd1, F_ZERO, 1'b0, 1'b0);
        nop(); expect_beat("inov", F_NAN, 3'd3, 1'b0, 3'b010);
        nop(); expect_beat("inov_ch0", 32'h40600000, 3'd0, 1'b0, 3'b000);
        nop(); expect_beat("inov_ch1", 32'hC0600000, 3'd1, 1'b0, 3'b000);

        // accumulator overflow on ch0 (3.5 + 2^32 + 2^32), then tlast clears it
        drive(3'd0, 32'h4F800000, 1'b0, 1'b0);
        drive(3'd0, 32'h4F800000, 1'b0, 1'b0);
        drive(3'd0, F_ZERO, 1'b0, 1'b1);
        nop(); expect_beat("ovf_first", 32'h4F800000, 3'd0, 1'b0, 3'b000);
        nop(); expect_beat("ovf", F_OVF, 3'd0, 1'b0, 3'b001);
        nop(); expect_beat("ovf_last", F_OVF, 3'd0, 1'b1, 3'b000);

        // stall with a result on the output and a beat in flight; beats offered while stalled are dropped
        drive(3'd1, F_ONE, 1'b0, 1'b0);
        drive(3'd1, F_ONE, 1'b0, 1'b0);
        nop(); nop();
        expect_beat("stall_pre", 32'hC0200000, 3'd1, 1'b0, 3'b000);
        i_aclken = 1'b0;
        drive(3'd0, F_ONE, 1'b0, 1'b0); expect_beat("stall_1", 32'hC0200000, 3'd1, 1'b0, 3'b000);
        drive(3'd0, F_ONE, 1'b0, 1'b0); expect_beat("stall_2", 32'hC0200000, 3'd1, 1'b0, 3'b000);
        drive(3'd0, F_ONE, 1'b0, 1'b0); expect_beat("stall_3", 32'hC0200000, 3'd1, 1'b0, 3'b000);
        i_aclken = 1'b1;
        nop(); expect_beat("stall_post", 32'hBFC00000, 3'd1, 1'b0, 3'b000);
        nop(); expect_none("stall_end");

        // reset with three beats in flight
        drive(3'd1, F_ONE, 1'b0, 1'b0);
        drive(3'd1, F_ONE, 1'b0, 1'b0);
        drive(3'd1, F_ONE, 1'b0, 1'b0);
        i_rst = 1'b1;
        nop();
        i_rst = 1'b0;
        expect_none("rst_mid_0");
        cmp("rst_mid_data", bus.o_axis_result_tdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            nop(); expect_none($sformatf("rst_mid_%0d", i + 1));
        end
        drive(3'd1, F_ONE, 1'b0, 1'b0);
        nop(); nop(); nop();
        expect_beat("rst_after", F_ONE, 3'd1, 1'b0, 3'b000);

        // denormal flushes to zero
        drive(3'd1, 32'h00000001, 1'b0, 1'b0);
        nop(); nop(); nop();
        expect_beat("denorm", F_ONE, 3'd1, 1'b0, 3'b000);

        // channel 5 is out of range: no beat, and ch1 (same low bits) untouched
        drive(3'd5, F_ONE, 1'b0, 1'b0);
        nop(); nop(); nop(); expect_none("ch5_a");
        nop(); expect_none("ch5_b");
        drive(3'd1, F_ZERO, 1'b0, 1'b0);
        nop(); nop(); nop();
        expect_beat("ch5_ch1", F_ONE, 3'd1, 1'b0, 3'b000);

        // cancellation gives +0; 2^-32 is truncated away
        drive(3'd0, F_ONE, 1'b0, 1'b0);
        drive(3'd0, F_ONE, 1'b1, 1'b0);
        drive(3'd0, 32'h2F800000, 1'b0, 1'b0);
        nop(); expect_beat("zero_a", F_ONE, 3'd0, 1'b0, 3'b000);
        nop(); expect_beat("zero_b", F_ZERO, 3'd0, 1'b0, 3'b000);
        nop(); expect_beat("zero_trunc", F_ZERO, 3'd0, 1'b0, 3'b000);
        nop(); expect_none("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
